// File: rtl/bram_ram_banked.sv
// Banked block RAM with registered read port and a reset-time zero-fill sequencer.
// All banks clear in parallel; ready marks when user reads and writes are accepted.
module bram_ram_banked #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 14,
    parameter int BANK_BITS      = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  ready
);

    localparam int OFF_W     = ADDR_WIDTH - BANK_BITS;
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int DEPTH_B   = 1 << OFF_W;

    localparam logic [OFF_W-1:0]     CNT_ONE   = OFF_W'(1'b1);
    localparam logic [OFF_W-1:0]     CNT_LAST  = {OFF_W{1'b1}};
    localparam logic [NUM_BANKS-1:0] BANK_ONE  = NUM_BANKS'(1'b1);
    localparam logic [NUM_BANKS-1:0] BANK_NONE = {NUM_BANKS{1'b0}};
    localparam logic [NUM_BANKS-1:0] BANK_ALL  = {NUM_BANKS{1'b1}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_INIT;

    state_t                state_q;
    state_t                state_d;
    logic [OFF_W-1:0]      clr_cnt_q;
    logic [OFF_W-1:0]      clr_cnt_d;
    logic                  ready_q;
    logic                  rd_vld_q;
    logic [BSEL_W-1:0]     bank_sel_q;

    logic [BSEL_W-1:0]     bank_s;
    logic [OFF_W-1:0]      offset_s;
    logic [OFF_W-1:0]      wr_off_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [NUM_BANKS-1:0]  we_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] out_s;
    logic [DATA_WIDTH-1:0] rd_bank_s [NUM_BANKS];

    assign offset_s = address[OFF_W-1:0];

    generate
        if (BANK_BITS > 0) begin : g_bank_dec
            assign bank_s = address[ADDR_WIDTH-1 -: BANK_BITS];
        end else begin : g_one_bank
            assign bank_s = 1'b0;
        end
    endgenerate

    // Sequencer next state: sweep offsets once, then stay in RUN until reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = RST_STATE;
        endcase
    end

    // RAM port steering: clear sweep owns all banks, otherwise the user port drives one bank.
    always_comb begin
        we_s      = BANK_NONE;
        wr_off_s  = offset_s;
        wr_data_s = in;
        rd_en_s   = 1'b0;
        if (reset) begin
            we_s = BANK_NONE;
        end else if (state_q == ST_CLEAR) begin
            we_s      = BANK_ALL;
            wr_off_s  = clr_cnt_q;
            wr_data_s = {DATA_WIDTH{1'b0}};
        end else if (state_q == ST_RUN) begin
            rd_en_s = 1'b1;
            if (load) begin
                we_s = BANK_ONE << bank_s;
            end else begin
                we_s = BANK_NONE;
            end
        end else begin
            we_s = BANK_NONE;
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem_q [DEPTH_B];
            logic [DATA_WIDTH-1:0] rd_q;

            // Read-first BRAM: the read sees the word as it was before this edge's write.
            always_ff @(posedge clk) begin
                if (we_s[b]) begin
                    mem_q[wr_off_s] <= wr_data_s;
                end
                if (rd_en_s) begin
                    rd_q <= mem_q[offset_s];
                end
            end

            assign rd_bank_s[b] = rd_q;
        end
    endgenerate

    // Control state, ready flag and the bank select that travels with the read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RST_STATE;
            clr_cnt_q  <= {OFF_W{1'b0}};
            ready_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            bank_sel_q <= {BSEL_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == ST_RUN);
            rd_vld_q  <= rd_en_s;
            if (rd_en_s) begin
                bank_sel_q <= bank_s;
            end
        end
    end

    // Output gating keeps out at zero until a real read has landed, whatever the RAM held.
    generate
        if (BANK_BITS > 0) begin : g_out_mux
            assign out_s = rd_vld_q ? rd_bank_s[bank_sel_q] : {DATA_WIDTH{1'b0}};
        end else begin : g_out_single
            assign out_s = rd_vld_q ? rd_bank_s[0] : {DATA_WIDTH{1'b0}};
        end
    endgenerate

    assign out   = out_s;
    assign ready = ready_q;

endmodule

// File: tb/tb_bram_ram_banked.sv
// Bench for bram_ram_banked: default-parameter instance plus a small no-clear instance,
// each compared every cycle against an array-based memory model.
module tb_bram_ram_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a = 1'b1;
    logic [15:0] in_a    = 16'h0000;
    logic [13:0] addr_a  = 14'h0000;
    logic        load_a  = 1'b0;
    logic [15:0] out_a;
    logic        ready_a;

    logic        reset_b = 1'b1;
    logic [7:0]  in_b    = 8'h00;
    logic [9:0]  addr_b  = 10'h000;
    logic        load_b  = 1'b0;
    logic [7:0]  out_b;
    logic        ready_b;

    bram_ram_banked dut_a (
        .clk(clk), .reset(reset_a), .in(in_a), .address(addr_a),
        .load(load_a), .out(out_a), .ready(ready_a)
    );

    bram_ram_banked #(
        .DATA_WIDTH(8), .ADDR_WIDTH(10), .BANK_BITS(3), .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset_b), .in(in_b), .address(addr_b),
        .load(load_b), .out(out_b), .ready(ready_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model A: memory becomes all-zero once 4096 un-reset edges have elapsed since reset.
    logic [15:0] mem_a [0:16383];
    logic [15:0] exp_out_a = 16'h0000;
    bit          exp_rdy_a = 1'b0;
    bit          valid_a   = 1'b0;
    int          since_a   = 0;

    always @(posedge clk) begin
        if (reset_a) begin
            valid_a   = 1'b1;
            since_a   = 0;
            exp_out_a = 16'h0000;
            exp_rdy_a = 1'b0;
        end else if (valid_a) begin
            if (exp_rdy_a) begin
                exp_out_a = mem_a[addr_a];
                if (load_a) mem_a[addr_a] = in_a;
            end else begin
                exp_out_a = 16'h0000;
                since_a++;
                if (since_a == 4096) begin
                    for (int i = 0; i < 16384; i++) mem_a[i] = 16'h0000;
                    exp_rdy_a = 1'b1;
                end
            end
        end
    end

    // Model B: no clear, ready one edge after reset; contents known only once written.
    logic [7:0] mem_b   [0:1023];
    bit         known_b [0:1023];
    logic [7:0] exp_out_b   = 8'h00;
    bit         exp_rdy_b   = 1'b0;
    bit         exp_known_b = 1'b0;
    bit         valid_b     = 1'b0;

    initial begin
        for (int i = 0; i < 1024; i++) known_b[i] = 1'b0;
    end

    always @(posedge clk) begin
        if (reset_b) begin
            valid_b     = 1'b1;
            exp_rdy_b   = 1'b0;
            exp_out_b   = 8'h00;
            exp_known_b = 1'b1;
        end else if (valid_b) begin
            if (exp_rdy_b) begin
                exp_out_b   = mem_b[addr_b];
                exp_known_b = known_b[addr_b];
                if (load_b) begin
                    mem_b[addr_b]   = in_b;
                    known_b[addr_b] = 1'b1;
                end
            end else begin
                exp_out_b   = 8'h00;
                exp_known_b = 1'b1;
                exp_rdy_b   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (valid_a) begin
            chk("a_ready", {31'd0, ready_a}, {31'd0, exp_rdy_a});
            chk("a_out", {16'd0, out_a}, {16'd0, exp_out_a});
        end
        if (valid_b) begin
            chk("b_ready", {31'd0, ready_b}, {31'd0, exp_rdy_b});
            if (exp_known_b) chk("b_out", {24'd0, out_b}, {24'd0, exp_out_b});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_a(input bit garbage, output int cnt);
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        cnt = 0;
        if (garbage) begin
            load_a = 1'b1;
            addr_a = 14'h0005;
            in_a   = 16'hDEAD;
        end
        while (ready_a !== 1'b1 && cnt < 6000) begin
            cnt++;
            step();
        end
        load_a = 1'b0;
    endtask

    task automatic wr_a(input logic [13:0] a, input logic [15:0] d);
        load_a = 1'b1;
        addr_a = a;
        in_a   = d;
        step();
        load_a = 1'b0;
    endtask

    task automatic rd_a(input logic [13:0] a, input logic [15:0] e, input string n);
        load_a = 1'b0;
        addr_a = a;
        step();
        chk(n, {16'd0, out_a}, {16'd0, e});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        step();
        chk("b_rst_ready", {31'd0, ready_b}, 32'd0);
        reset_b = 1'b0;
        step();
        chk("b_init_ready", {31'd0, ready_b}, 32'd1);

        sweep_a(1'b0, cnt);
        chk("a_clear_cycles", cnt, 32'd4096);
        rd_a(14'h0000, 16'h0000, "a_clr_0000");
        rd_a(14'h1FFF, 16'h0000, "a_clr_1fff");
        rd_a(14'h3FFF, 16'h0000, "a_clr_3fff");

        wr_a(14'h0123, 16'hBEEF);
        wr_a(14'h1123, 16'h1234);
        wr_a(14'h2123, 16'hA5A5);
        wr_a(14'h3123, 16'h5A5A);
        rd_a(14'h0123, 16'hBEEF, "a_bank0");
        rd_a(14'h1123, 16'h1234, "a_bank1");
        rd_a(14'h2123, 16'hA5A5, "a_bank2");
        rd_a(14'h3123, 16'h5A5A, "a_bank3");

        wr_a(14'h0042, 16'h1111);
        load_a = 1'b1;
        addr_a = 14'h0042;
        in_a   = 16'h7777;
        step();
        chk("a_rdw_old", {16'd0, out_a}, 32'h0000_1111);
        load_a = 1'b0;
        step();
        chk("a_rdw_new", {16'd0, out_a}, 32'h0000_7777);

        for (int i = 0; i < 400; i++) begin
            load_a = 1'($urandom_range(0, 1));
            addr_a = {2'($urandom_range(0, 3)), 12'h120 + 12'($urandom_range(0, 7))};
            in_a   = 16'($urandom);
            step();
        end
        load_a = 1'b0;

        wr_a(14'h3FFF, 16'hFFFF);
        rd_a(14'h3FFF, 16'hFFFF, "a_prewrite");
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        load_a  = 1'b1;
        addr_a  = 14'h0005;
        in_a    = 16'hDEAD;
        repeat (2000) step();
        chk("a_mid_sweep_ready", {31'd0, ready_a}, 32'd0);
        sweep_a(1'b1, cnt);
        chk("a_restart_cycles", cnt, 32'd4096);
        rd_a(14'h3FFF, 16'h0000, "a_restart_3fff");
        rd_a(14'h0005, 16'h0000, "a_ignored_load");

        for (int i = 0; i < 1024; i++) begin
            load_b = 1'b1;
            addr_b = 10'(i);
            in_b   = 8'($urandom);
            step();
        end
        load_b = 1'b1;
        addr_b = 10'h3FF;
        in_b   = 8'hC3;
        step();
        load_b = 1'b0;
        step();
        chk("b_literal", {24'd0, out_b}, 32'h0000_00C3);
        for (int i = 0; i < 600; i++) begin
            load_b = 1'($urandom_range(0, 1));
            addr_b = 10'($urandom);
            in_b   = 8'($urandom);
            step();
        end
        load_b = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
